sound_square_channel: RTL and testbench

SOUND_SQUARE_CHANNEL -- requirements
Module: sound_square_channel

---
 rtl/sound_pkg.sv | 33 +++
 rtl/sound_freq_sweep.sv | 61 ++++++
 rtl/sound_square_channel.sv | 159 +++++++++++++++
 tb/tb_sound_square_channel.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Items shared by the sound channels: default parameter values, the duty
// pattern table and the register field layouts.
package sound_pkg;

  localparam int unsigned DEF_SWEEP_EN = 0;
  localparam int unsigned DEF_FREQ_W   = 11;
  localparam int unsigned DEF_LEN_W    = 6;
  localparam int unsigned DEF_VOL_W    = 4;
  localparam int unsigned DEF_PRESCALE = 4;

  // Output-high steps of the duty cycle, indexed by NR1[7:6]. Bit n belongs to step n.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b0111_1110, 8'b1000_0111, 8'b1000_0001, 8'b0000_0001
  };

  localparam int unsigned NR1_DUTY_LSB   = 6;
  localparam int unsigned NR4_TRIG_BIT   = 7;
  localparam int unsigned NR4_LEN_EN_BIT = 6;

  typedef struct packed {
    logic       rsvd;
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
  } nr0_t;

  typedef struct packed {
    logic [3:0] vol;
    logic       add;
    logic [2:0] period;
  } nr2_t;

endpackage

// File: rtl/sound_freq_sweep.sv
// Frequency sweep unit: it holds the shadow frequency, steps it on sweep ticks,
// and flags any result that overflows the frequency range.
module sound_freq_sweep
  import sound_pkg::*;
#(
  parameter int unsigned FREQ_W = DEF_FREQ_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic              i_tick,
  input  logic [7:0]        i_nr0,
  input  logic [FREQ_W-1:0] i_freq,
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_ovf_c
);

  localparam int unsigned SUM_W = FREQ_W + 1;

  nr0_t              w_nr0;
  logic [FREQ_W-1:0] w_base;
  logic [SUM_W-1:0]  w_delta;
  logic [SUM_W-1:0]  w_new;
  logic              w_calc;
  logic              w_unused;
  logic [FREQ_W-1:0] r_shadow;
  logic [2:0]        r_cnt;

  assign w_nr0    = nr0_t'(i_nr0);
  assign w_unused = w_nr0.rsvd;
  // The trigger overflow check uses the frequency that is loaded in the same cycle
  assign w_base   = i_trig ? i_freq : r_shadow;
  assign w_calc   = i_tick && !i_trig && (w_nr0.period != 3'd0) && (r_cnt <= 3'd1);

  always_comb begin
    w_delta = SUM_W'(w_base >> w_nr0.shift);
    if (w_nr0.negate) w_new = {1'b0, w_base} - w_delta;
    else              w_new = {1'b0, w_base} + w_delta;
  end

  assign o_ovf_c = w_new[FREQ_W] && ((i_trig && (w_nr0.shift != 3'd0)) || w_calc);
  assign o_freq  = r_shadow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (i_trig) begin
      r_shadow <= i_freq;
      r_cnt    <= w_nr0.period;
    end else if (i_tick && (w_nr0.period != 3'd0)) begin
      if (w_calc) begin
        r_cnt <= w_nr0.period;
        if (!w_new[FREQ_W] && (w_nr0.shift != 3'd0)) r_shadow <= w_new[FREQ_W-1:0];
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/sound_square_channel.sv
// Square-wave sound channel. It combines the duty generator, length counter and
// volume envelope, and adds the frequency sweep when SWEEP_EN is set.
module sound_square_channel
  import sound_pkg::*;
#(
  parameter int unsigned SWEEP_EN = DEF_SWEEP_EN,
  parameter int unsigned FREQ_W   = DEF_FREQ_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned VOL_W    = DEF_VOL_W,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic             I_CLK,
  input  logic             I_RESET_L,
  input  logic [7:0]       I_NR0,
  input  logic [7:0]       I_NR1,
  input  logic [7:0]       I_NR2,
  input  logic [7:0]       I_NR3,
  input  logic [7:0]       I_NR4,
  input  logic             I_NR1_WR,
  input  logic             I_NR2_WR,
  input  logic             I_NR4_WR,
  input  logic             I_TICK_LEN,
  input  logic             I_TICK_SWEEP,
  input  logic             I_TICK_ENV,
  output logic [VOL_W-1:0] O_SAMPLE,
  output logic             O_ON
);

  localparam int unsigned TIMER_W = FREQ_W + $clog2(PRESCALE) + 1;
  localparam int unsigned LCNT_W  = LEN_W + 1;
  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  nr2_t               w_nr2;
  logic               w_trig, w_dac_en, w_tick_len, w_tick_env, w_tick_sweep;
  logic               w_sweep_ovf, w_len_expire, w_on_nxt, w_unused;
  logic [FREQ_W-1:0]  w_freq_live, w_freq;
  logic [7:0]         w_pattern;
  logic [LCNT_W-1:0]  w_len_load, w_len_nxt;
  logic [VOL_W-1:0]   w_vol_nxt, w_sample_nxt;
  logic [2:0]         w_env_nxt, w_step_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;

  logic               r_on;
  logic [VOL_W-1:0]   r_sample, r_vol;
  logic [2:0]         r_env_cnt, r_step;
  logic [LCNT_W-1:0]  r_len;
  logic [TIMER_W-1:0] r_timer;

  function automatic logic [TIMER_W-1:0] f_period(input logic [FREQ_W-1:0] freq);
    return ((TIMER_W'(1) << FREQ_W) - TIMER_W'(freq)) * TIMER_W'(PRESCALE);
  endfunction

  assign w_nr2        = nr2_t'(I_NR2);
  assign w_trig       = I_NR4_WR && I_NR4[NR4_TRIG_BIT];
  assign w_dac_en     = |{w_nr2.vol, w_nr2.add};
  // A trigger takes priority over any frame-sequencer tick in the same cycle
  assign w_tick_len   = I_TICK_LEN && !w_trig;
  assign w_tick_env   = I_TICK_ENV && !w_trig;
  assign w_tick_sweep = I_TICK_SWEEP && !w_trig;
  assign w_freq_live  = FREQ_W'({I_NR4[2:0], I_NR3});
  assign w_pattern    = DUTY_TABLE[I_NR1[NR1_DUTY_LSB +: 2]];
  assign w_len_load   = (LCNT_W'(1) << LEN_W) - LCNT_W'(I_NR1[LEN_W-1:0]);
  assign w_unused     = ^{I_NR0, I_NR4[5:3], I_NR2_WR, I_TICK_SWEEP};

  generate
    if (SWEEP_EN != 0) begin : g_sweep
      sound_freq_sweep #(.FREQ_W(FREQ_W)) u_sweep (
        .i_clk   (I_CLK),
        .i_rst_n (I_RESET_L),
        .i_trig  (w_trig),
        .i_tick  (w_tick_sweep),
        .i_nr0   (I_NR0),
        .i_freq  (w_freq_live),
        .o_freq  (w_freq),
        .o_ovf_c (w_sweep_ovf)
      );
    end else begin : g_no_sweep
      assign w_freq      = w_freq_live;
      assign w_sweep_ovf = 1'b0;
    end
  endgenerate

  always_comb begin
    w_on_nxt     = r_on;
    w_vol_nxt    = r_vol;
    w_env_nxt    = r_env_cnt;
    w_len_nxt    = r_len;
    w_timer_nxt  = r_timer;
    w_step_nxt   = r_step;
    w_len_expire = 1'b0;

    if (I_NR1_WR) begin
      w_len_nxt = w_len_load;
    end else if (w_tick_len && I_NR4[NR4_LEN_EN_BIT] && (r_len != '0)) begin
      w_len_nxt    = r_len - LCNT_W'(1);
      w_len_expire = (r_len == LCNT_W'(1));
    end

    if (w_tick_env && (w_nr2.period != 3'd0)) begin
      if (r_env_cnt <= 3'd1) begin
        w_env_nxt = w_nr2.period;
        if (w_nr2.add) begin
          if (r_vol != VOL_MAX) w_vol_nxt = r_vol + VOL_W'(1);
        end else if (r_vol != '0) begin
          w_vol_nxt = r_vol - VOL_W'(1);
        end
      end else begin
        w_env_nxt = r_env_cnt - 3'd1;
      end
    end

    if (r_on) begin
      if (r_timer <= TIMER_W'(1)) begin
        w_timer_nxt = f_period(w_freq);
        w_step_nxt  = r_step + 3'd1;
      end else begin
        w_timer_nxt = r_timer - TIMER_W'(1);
      end
    end

    if (w_trig) begin
      w_on_nxt    = 1'b1;
      w_vol_nxt   = VOL_W'(w_nr2.vol);
      w_env_nxt   = w_nr2.period;
      w_timer_nxt = f_period(w_freq_live);
      w_step_nxt  = 3'd0;
      if (w_len_nxt == '0) w_len_nxt = LCNT_W'(1) << LEN_W;
    end

    if (w_len_expire || w_sweep_ovf || !w_dac_en) w_on_nxt = 1'b0;

    // The sample is built from next-state values so that it changes together with O_ON
    w_sample_nxt = (w_on_nxt && w_pattern[w_step_nxt]) ? w_vol_nxt : '0;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_on      <= 1'b0;
      r_sample  <= '0;
      r_vol     <= '0;
      r_env_cnt <= '0;
      r_step    <= '0;
      r_len     <= '0;
      r_timer   <= '0;
    end else begin
      r_on      <= w_on_nxt;
      r_sample  <= w_sample_nxt;
      r_vol     <= w_vol_nxt;
      r_env_cnt <= w_env_nxt;
      r_step    <= w_step_nxt;
      r_len     <= w_len_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  assign O_ON     = r_on;
  assign O_SAMPLE = r_sample;

endmodule

// File: tb/tb_sound_square_channel.sv
// Scoreboard bench for sound_square_channel. It drives a plain channel (sweep off)
// and a sweep-enabled channel from the same register inputs.
module tb_sound_square_channel;

  logic       clk;
  logic       rst_l;
  logic [7:0] nr0, nr1, nr2, nr3, nr4;
  logic       nr1_wr, nr2_wr, nr4_wr, tick_len, tick_sweep, tick_env;
  logic [3:0] smp0, smp1;
  logic       on0, on1;

  typedef struct {
    string tag;
    int    sel;
    int    exp_on;
    int    exp_smp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] duty_pat [4] = '{8'h01, 8'h81, 8'h87, 8'h7E};

  sound_square_channel dut0 (
    .I_CLK(clk), .I_RESET_L(rst_l),
    .I_NR0(nr0), .I_NR1(nr1), .I_NR2(nr2), .I_NR3(nr3), .I_NR4(nr4),
    .I_NR1_WR(nr1_wr), .I_NR2_WR(nr2_wr), .I_NR4_WR(nr4_wr),
    .I_TICK_LEN(tick_len), .I_TICK_SWEEP(tick_sweep), .I_TICK_ENV(tick_env),
    .O_SAMPLE(smp0), .O_ON(on0)
  );

  sound_square_channel #(.SWEEP_EN(1)) dut1 (
    .I_CLK(clk), .I_RESET_L(rst_l),
    .I_NR0(nr0), .I_NR1(nr1), .I_NR2(nr2), .I_NR3(nr3), .I_NR4(nr4),
    .I_NR1_WR(nr1_wr), .I_NR2_WR(nr2_wr), .I_NR4_WR(nr4_wr),
    .I_TICK_LEN(tick_len), .I_TICK_SWEEP(tick_sweep), .I_TICK_ENV(tick_env),
    .O_SAMPLE(smp1), .O_ON(on1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pat_smp(input int duty, input int k, input int vol);
    logic [7:0] p;
    p = duty_pat[duty];
    return p[(k / 4) % 8] ? vol : 0;
  endfunction

  task automatic push(input string tag, input int sel, input int on, input int smp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp_on = on; e.exp_smp = smp;
    sb_q.push_back(e);
  endtask

  task automatic push_both(input string tag, input int on, input int smp);
    push({tag, "_d0"}, 0, on, smp);
    push({tag, "_d1"}, 1, on, smp);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == 0) begin
        check_val({e.tag, "_on"}, 32'(on0), e.exp_on);
        check_val({e.tag, "_smp"}, 32'(smp0), e.exp_smp);
      end else begin
        check_val({e.tag, "_on"}, 32'(on1), e.exp_on);
        check_val({e.tag, "_smp"}, 32'(smp1), e.exp_smp);
      end
    end
  endtask

  // One clock edge: the inputs set up before the call are applied, the pulses are cleared, and the outputs are compared
  task automatic step();
    @(posedge clk);
    #1;
    nr1_wr = 0; nr2_wr = 0; nr4_wr = 0;
    tick_len = 0; tick_sweep = 0; tick_env = 0;
    drain();
  endtask

  initial begin
    rst_l = 0;
    nr0 = 0; nr1 = 0; nr2 = 0; nr3 = 0; nr4 = 0;
    nr1_wr = 0; nr2_wr = 0; nr4_wr = 0;
    tick_len = 0; tick_sweep = 0; tick_env = 0;
    repeat (3) @(posedge clk);
    #1;
    push_both("in_reset", 0, 0); drain();
    rst_l = 1;
    push_both("idle", 0, 0); step();

    // Duty 2 at freq 0x7FF: each step lasts 4 clocks, with output high on steps 0,1,2,7
    nr1 = 8'h80; nr2 = 8'hF0; nr3 = 8'hFF; nr4 = 8'h87; nr4_wr = 1;
    push_both("duty_trig", 1, 15); step();
    for (int k = 1; k < 40; k++) begin
      push_both("duty", 1, pat_smp(2, k, 15)); step();
    end
    nr2 = 8'h00;
    push_both("dac_off", 0, 0); step();
    nr2 = 8'h07; nr4_wr = 1;
    push_both("trig_nodac", 0, 0); step();

    // A length of 2 expires on the second tick
    nr1 = 8'h3E; nr1_wr = 1; nr2 = 8'hF0; nr3 = 8'hFF; nr4 = 8'hC7;
    push_both("len_load", 0, 0); step();
    nr4_wr = 1;
    push_both("len_trig", 1, 15); step();
    tick_len = 1;
    push_both("len_tick1", 1, pat_smp(0, 1, 15)); step();
    push_both("len_idle", 1, pat_smp(0, 2, 15)); step();
    tick_len = 1;
    push_both("len_tick2", 0, 0); step();

    // Trigger beats a length tick; a length load beats a length tick
    nr1 = 8'h3F; nr1_wr = 1;
    push_both("pri_load1", 0, 0); step();
    nr4_wr = 1; tick_len = 1;
    push_both("pri_trig_tick", 1, 15); step();
    tick_len = 1;
    push_both("pri_len_was1", 0, 0); step();
    nr4_wr = 1;
    push_both("pri_retrig", 1, 15); step();
    nr1 = 8'h3E; nr1_wr = 1; tick_len = 1;
    push_both("pri_wr_tick", 1, pat_smp(0, 1, 15)); step();
    tick_len = 1;
    push_both("pri_tick_a", 1, pat_smp(0, 2, 15)); step();
    tick_len = 1;
    push_both("pri_tick_b", 0, 0); step();

    // Envelope: freq 0 keeps duty step 0 (high) for the whole sequence, so the sample equals the volume
    nr0 = 8'h00; nr1 = 8'h80; nr2 = 8'h19; nr3 = 8'h00; nr4 = 8'h80; nr4_wr = 1;
    push_both("env_trig", 1, 1); step();
    for (int j = 1; j <= 20; j++) begin
      tick_env = 1;
      push_both("env_up", 1, (j + 1 > 15) ? 15 : j + 1); step();
    end
    nr2 = 8'hF8; tick_env = 1;
    push_both("env_freeze", 1, 15); step();
    nr2 = 8'h11;
    for (int j = 1; j <= 3; j++) begin
      tick_env = 1;
      push_both("env_down", 1, 15 - j); step();
    end

    // Sweep: an overflow at trigger time, then an overflow on a sweep tick
    nr0 = 8'h11; nr1 = 8'h80; nr2 = 8'hF0; nr3 = 8'hF0; nr4 = 8'h87; nr4_wr = 1;
    push("swp_trig_ovf_d0", 0, 1, 15);
    push("swp_trig_ovf_d1", 1, 0, 0);
    step();
    nr0 = 8'h12; nr3 = 8'h00; nr4 = 8'h86; nr4_wr = 1;
    push_both("swp_trig_ok", 1, 15); step();
    tick_sweep = 1;
    push_both("swp_tick1", 1, 15); step();
    tick_sweep = 1;
    push("swp_tick2_d0", 0, 1, 15);
    push("swp_tick2_d1", 1, 0, 0);
    step();

    // Asserting reset mid-tone silences both channels at once; releasing it leaves them silent
    nr0 = 8'h00; nr2 = 8'hF0; nr3 = 8'h00; nr4 = 8'h80; nr4_wr = 1;
    push_both("rst_pre", 1, 15); step();
    push_both("rst_run", 1, 15); step();
    #2 rst_l = 0;
    #1;
    push_both("rst_async", 0, 0); drain();
    @(posedge clk);
    #1;
    push_both("rst_hold", 0, 0); drain();
    rst_l = 1;
    for (int j = 0; j < 5; j++) begin
      push_both("rst_quiet", 0, 0); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
